// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer.
// Fetch/execute/halt control, PC, trap redirect, debug dpc.
module pc_seq #(
  parameter int unsigned Width = 32,
  parameter logic [Width-1:0] ResetVector = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [Width-1:0] pc,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic             ir_load,
  output logic             exec_en,
  input  logic             exec_done,
  input  logic [Width-1:0] next_pc,
  input  logic             ialign,
  input  logic [Width-1:0] trap_vec,
  output logic             trap,
  output logic [Width-1:0] trap_pc,
  output logic             retire,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             halted,
  input  logic             dpc_we,
  input  logic [Width-1:0] dpc_wdata
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic commit;
  logic dpc_wr;

  assign commit = (state == EXEC) && exec_done;
  assign dpc_wr = (state == HALTED) && dpc_we;

  assign fetch_req = (state == FETCH);
  assign exec_en   = (state == EXEC);
  assign halted    = (state == HALTED);
  assign ir_load   = (state == FETCH) && fetch_ack;

  // Next state: halt is only sampled at boot and instruction boundaries
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:   state_nx = halt_req ? HALTED : FETCH;
      FETCH:  if (fetch_ack) state_nx = EXEC;
      EXEC:   if (exec_done) state_nx = halt_req ? HALTED : FETCH;
      HALTED: if (resume_req) state_nx = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  // PC update: commit, trap redirect, or debug write while halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= ResetVector;
    end else if (commit) begin
      pc <= ialign ? {trap_vec[Width-1:1], 1'b0} : next_pc;
    end else if (dpc_wr) begin
      pc <= dpc_wdata;
    end
  end

  // Trap capture and one-cycle commit pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pc <= '0;
      trap    <= 1'b0;
      retire  <= 1'b0;
    end else begin
      trap   <= commit && ialign;
      retire <= commit && !ialign;
      if (commit && ialign) trap_pc <= pc;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed and randomized checks of pc_seq
// against an in-bench behavioural model.
module tb_pc_seq;

  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        fetch_req;
  logic        fetch_ack = 1'b0;
  logic        ir_load;
  logic        exec_en;
  logic        exec_done = 1'b0;
  logic [31:0] next_pc = '0;
  logic        ialign = 1'b0;
  logic [31:0] trap_vec = '0;
  logic        trap;
  logic [31:0] trap_pc;
  logic        retire;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        halted;
  logic        dpc_we = 1'b0;
  logic [31:0] dpc_wdata = '0;

  int checks = 0;
  int errors = 0;

  pc_seq #(.Width(32), .ResetVector(RV)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .ir_load(ir_load), .exec_en(exec_en),
    .exec_done(exec_done), .next_pc(next_pc),
    .ialign(ialign), .trap_vec(trap_vec),
    .trap(trap), .trap_pc(trap_pc), .retire(retire),
    .halt_req(halt_req), .resume_req(resume_req),
    .halted(halted), .dpc_we(dpc_we),
    .dpc_wdata(dpc_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: which activity the core is busy with
  bit          m_boot, m_fetch, m_exec, m_halt;
  logic [31:0] m_pc, m_trap_pc;
  bit          m_trap, m_retire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1; m_fetch <= 0; m_exec <= 0; m_halt <= 0;
      m_pc <= RV; m_trap_pc <= 0;
      m_trap <= 0; m_retire <= 0;
    end else begin
      m_trap <= 0;
      m_retire <= 0;
      if (m_boot) begin
        m_boot <= 0;
        m_halt <= halt_req;
        m_fetch <= !halt_req;
      end else if (m_fetch) begin
        if (fetch_ack) begin
          m_fetch <= 0;
          m_exec <= 1;
        end
      end else if (m_exec) begin
        if (exec_done) begin
          if (ialign) begin
            m_trap_pc <= m_pc;
            m_pc <= trap_vec & ~32'd1;
            m_trap <= 1;
          end else begin
            m_pc <= next_pc;
            m_retire <= 1;
          end
          m_exec <= 0;
          m_halt <= halt_req;
          m_fetch <= !halt_req;
        end
      end else if (m_halt) begin
        if (dpc_we) m_pc <= dpc_wdata;
        if (resume_req) begin
          m_halt <= 0;
          m_fetch <= 1;
        end
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    check("m_pc", pc, m_pc);
    check("m_fetch_req", 32'(fetch_req), 32'(m_fetch));
    check("m_exec_en", 32'(exec_en), 32'(m_exec));
    check("m_halted", 32'(halted), 32'(m_halt));
    check("m_ir_load", 32'(ir_load),
          32'(m_fetch && fetch_ack));
    check("m_trap", 32'(trap), 32'(m_trap));
    check("m_retire", 32'(retire), 32'(m_retire));
    check("m_trap_pc", trap_pc, m_trap_pc);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int irl;

  initial begin
    // Reset state
    @(posedge clk);
    #2;
    check("rst_pc", pc, RV);
    check("rst_fetch_req", 32'(fetch_req), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_exec_en", 32'(exec_en), 0);
    check("rst_trap_pc", trap_pc, 0);
    check("rst_retire", 32'(retire), 0);
    cyc();
    rst_n = 1'b1;
    // BOOT cycle, then fetch at reset vector
    check("boot_no_fetch", 32'(fetch_req), 0);
    cyc();
    check("t1_fetch_req", 32'(fetch_req), 1);
    check("t1_pc", pc, 32'h100);
    fetch_ack = 1; exec_done = 1; next_pc = 32'h104;
    cyc();
    check("t1_exec_en", 32'(exec_en), 1);
    cyc();
    fetch_ack = 0; exec_done = 0;
    check("t1_pc_next", pc, 32'h104);
    check("t1_retire", 32'(retire), 1);
    // Fetch wait of 3 cycles
    irl = 0;
    for (int i = 0; i < 4; i++) begin
      check("t2_fetch_req", 32'(fetch_req), 1);
      check("t2_pc_stable", pc, 32'h104);
      if (i == 3) fetch_ack = 1;
      #1;
      if (ir_load) irl++;
      cyc();
    end
    fetch_ack = 0;
    check("t2_ir_load_once", irl, 1);
    check("t2_exec_en", 32'(exec_en), 1);
    // Misaligned jump
    exec_done = 1; next_pc = 32'h200;
    cyc();
    exec_done = 0; fetch_ack = 1;
    check("t3_pc_200", pc, 32'h200);
    cyc();
    fetch_ack = 0;
    exec_done = 1; ialign = 1; trap_vec = 32'h801;
    cyc();
    exec_done = 0; ialign = 0;
    check("t3_pc_vec", pc, 32'h800);
    check("t3_trap_pc", trap_pc, 32'h200);
    check("t3_trap", 32'(trap), 1);
    check("t3_retire", 32'(retire), 0);
    // Halt during EXEC
    fetch_ack = 1;
    cyc();
    fetch_ack = 0; halt_req = 1;
    cyc();
    cyc();
    check("t5_exec_hold", 32'(exec_en), 1);
    check("t5_not_halted", 32'(halted), 0);
    exec_done = 1; next_pc = 32'h804;
    cyc();
    exec_done = 0;
    check("t5_retire", 32'(retire), 1);
    check("t5_halted", 32'(halted), 1);
    check("t5_pc", pc, 32'h804);
    dpc_we = 1; dpc_wdata = 32'h900;
    cyc();
    dpc_we = 0;
    check("t5_dpc_write", pc, 32'h900);
    // Single step with halt held; dpc write in FETCH ignored
    resume_req = 1;
    cyc();
    resume_req = 0;
    check("t5_resume_fetch", 32'(fetch_req), 1);
    dpc_we = 1; dpc_wdata = 32'hdead;
    cyc();
    dpc_we = 0;
    check("t5_dpc_ignored", pc, 32'h900);
    fetch_ack = 1;
    cyc();
    fetch_ack = 0; exec_done = 1; next_pc = 32'h904;
    cyc();
    exec_done = 0;
    check("t5_step_halted", 32'(halted), 1);
    check("t5_step_pc", pc, 32'h904);
    halt_req = 0; resume_req = 1;
    cyc();
    resume_req = 0;
    check("t6_fetching", 32'(fetch_req), 1);
    // Async reset mid-fetch, no clock edge
    halt_req = 1;
    rst_n = 0;
    #1;
    check("t6_async_pc", pc, RV);
    check("t6_async_fetch", 32'(fetch_req), 0);
    check("t6_async_halted", 32'(halted), 0);
    cyc();
    rst_n = 1;
    cyc();
    check("t4_halt_on_reset", 32'(halted), 1);
    check("t4_no_fetch", 32'(fetch_req), 0);
    dpc_we = 1; dpc_wdata = 32'h300; resume_req = 1;
    cyc();
    dpc_we = 0; resume_req = 0;
    check("t4_fetch_pc", pc, 32'h300);
    check("t4_fetch_req", 32'(fetch_req), 1);
    fetch_ack = 1;
    cyc();
    fetch_ack = 0; exec_done = 1; next_pc = 32'h304;
    cyc();
    exec_done = 0;
    check("t4_halted_again", 32'(halted), 1);
    check("t4_pc_next", pc, 32'h304);
    cyc();
    check("t4_stays_halted", 32'(fetch_req), 0);
    halt_req = 0;
    // Randomized phase, checked by the compare process
    for (int i = 0; i < 4000; i++) begin
      fetch_ack = ($urandom_range(0, 2) == 0);
      exec_done = ($urandom_range(0, 2) == 0);
      ialign = ($urandom_range(0, 3) == 0);
      next_pc = $urandom;
      trap_vec = $urandom;
      resume_req = ($urandom_range(0, 3) == 0);
      dpc_we = ($urandom_range(0, 3) == 0);
      dpc_wdata = $urandom;
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        #1;
        check("r_async_pc", pc, RV);
        check("r_async_fetch", 32'(fetch_req), 0);
        cyc();
        rst_n = 1;
      end
      cyc();
    end
    fetch_ack = 0; exec_done = 0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
